// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master, slave and RAM: state encoding,
// command codes and default frame geometry.
package spi_pkg;

   localparam int FRAME_BITS_DEF = 10;
   localparam int DATA_BITS_DEF  = 8;

   // Master FSM state encoding (unused codes 6/7 recover to IDLE)
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CMD   = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_TURN  = 3'd3;
   localparam logic [2:0] ST_READ  = 3'd4;
   localparam logic [2:0] ST_GAP   = 3'd5;

   // Command field carried in the top two bits of each frame
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   // Only rd-data frames turn the bus around and clock a byte back on MISO
   function automatic logic is_read_data(input logic [1:0] cmd);
      return (cmd == CMD_RD_DATA);
   endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath for spi_master: transmit shift register (MSB first), receive
// shadow register and the shared bit down-counter.
module spi_master_shifter
   import spi_pkg::*;
#(
   parameter int FRAME_BITS = FRAME_BITS_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF,
   parameter int CNT_W      = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_load,
   input  logic [FRAME_BITS-1:0] i_din,
   input  logic                  i_shift_out,
   input  logic                  i_shift_in,
   input  logic                  i_miso,
   input  logic                  i_cnt_load,
   input  logic [CNT_W-1:0]      i_cnt_val,
   input  logic                  i_cnt_dec,
   output logic                  o_out_bit,
   output logic                  o_next_bit,
   output logic [DATA_BITS-1:0]  o_rx_next,
   output logic                  o_cnt_zero
);

   logic [FRAME_BITS-1:0] r_tx;
   // Only DATA_BITS-1 bits are kept: the final bit comes straight from MISO
   // on the commit edge, so the shadow never needs the full byte width.
   logic [DATA_BITS-2:0]  r_rx;
   logic [CNT_W-1:0]      r_cnt;

   assign o_out_bit  = r_tx[FRAME_BITS-1];
   assign o_next_bit = r_tx[FRAME_BITS-2];
   assign o_rx_next  = {r_rx, i_miso};
   assign o_cnt_zero = (r_cnt == '0);

   // Transmit register: load the captured frame, then shift left MSB first
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_tx <= '0;
      else if (i_load)
         r_tx <= i_din;
      else if (i_shift_out)
         r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
   end

   // Receive shadow: accumulate MISO bits, MSB first
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_rx <= '0;
      else if (i_shift_in)
         r_rx <= o_rx_next[DATA_BITS-2:0];
   end

   // Bit counter: loaded per phase, counts down and holds at zero
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_cnt <= '0;
      else if (i_cnt_load)
         r_cnt <= i_cnt_val;
      else if (i_cnt_dec && (r_cnt != '0))
         r_cnt <= r_cnt - CNT_W'(1);
   end

endmodule

// File: rtl/spi_master.sv
// SPI master: sends one command+payload frame per start request and, for
// rd-data frames, turns the bus around and reads a byte back on MISO.
module spi_master
   import spi_pkg::*;
#(
   parameter int FRAME_BITS = FRAME_BITS_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF,
   parameter int GAP_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [FRAME_BITS-1:0] din,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_BITS-1:0]  rx_data,
   output logic                  rx_valid,
   output logic                  SS_n,
   output logic                  MOSI,
   input  logic                  MISO
);

   localparam int CNT_MAX  = (FRAME_BITS > DATA_BITS) ? FRAME_BITS : DATA_BITS;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam int GAP_W    = $clog2(GAP_LOAD + 2);

   localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(DATA_BITS - 1);
   localparam logic [GAP_W-1:0] GAP_INIT   = GAP_W'(GAP_LOAD);

   logic [2:0]           r_state;
   logic [1:0]           r_cmd;
   logic [GAP_W-1:0]     r_gap_cnt;

   logic                 w_load;
   logic                 w_shift_out;
   logic                 w_shift_in;
   logic                 w_cnt_load;
   logic [CNT_W-1:0]     w_cnt_val;
   logic                 w_cnt_dec;
   logic                 w_out_bit;
   logic                 w_next_bit;
   logic [DATA_BITS-1:0] w_rx_next;
   logic                 w_cnt_zero;

   spi_master_shifter #(
      .FRAME_BITS (FRAME_BITS),
      .DATA_BITS  (DATA_BITS),
      .CNT_W      (CNT_W)
   ) u_shifter (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_load      (w_load),
      .i_din       (din),
      .i_shift_out (w_shift_out),
      .i_shift_in  (w_shift_in),
      .i_miso      (MISO),
      .i_cnt_load  (w_cnt_load),
      .i_cnt_val   (w_cnt_val),
      .i_cnt_dec   (w_cnt_dec),
      .o_out_bit   (w_out_bit),
      .o_next_bit  (w_next_bit),
      .o_rx_next   (w_rx_next),
      .o_cnt_zero  (w_cnt_zero)
   );

   // Datapath strobes decoded from the current state
   always_comb begin
      w_load      = (r_state == ST_IDLE) && start;
      w_shift_out = (r_state == ST_SHIFT) && !w_cnt_zero;
      w_shift_in  = (r_state == ST_READ);
      w_cnt_load  = (r_state == ST_CMD) || (r_state == ST_TURN);
      w_cnt_val   = (r_state == ST_TURN) ? READ_LOAD : SHIFT_LOAD;
      w_cnt_dec   = (r_state == ST_SHIFT) || (r_state == ST_READ);
   end

   // Frame sequencer; every output is registered alongside the state.
   // MOSI is driven one bit ahead from the shifter (next_bit) so the bit
   // appears in the same cycle the counter names it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cmd     <= '0;
         r_gap_cnt <= '0;
         SS_n      <= 1'b1;
         MOSI      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rx_valid  <= 1'b0;
         rx_data   <= '0;
      end else begin
         done     <= 1'b0;
         rx_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               SS_n <= 1'b1;
               MOSI <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  r_cmd   <= din[FRAME_BITS-1 -: 2];
                  SS_n    <= 1'b0;
                  MOSI    <= din[FRAME_BITS-1];
                  busy    <= 1'b1;
                  r_state <= ST_CMD;
               end
            end
            ST_CMD: begin
               MOSI    <= w_out_bit;
               r_state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (!w_cnt_zero) begin
                  MOSI <= w_next_bit;
               end else if (is_read_data(r_cmd)) begin
                  MOSI    <= 1'b0;
                  r_state <= ST_TURN;
               end else begin
                  SS_n      <= 1'b1;
                  MOSI      <= 1'b0;
                  done      <= 1'b1;
                  r_gap_cnt <= GAP_INIT;
                  r_state   <= ST_GAP;
               end
            end
            ST_TURN: begin
               MOSI    <= 1'b0;
               r_state <= ST_READ;
            end
            ST_READ: begin
               if (w_cnt_zero) begin
                  SS_n      <= 1'b1;
                  done      <= 1'b1;
                  rx_valid  <= 1'b1;
                  rx_data   <= w_rx_next;
                  r_gap_cnt <= GAP_INIT;
                  r_state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               SS_n <= 1'b1;
               MOSI <= 1'b0;
               if (r_gap_cnt == '0) begin
                  busy    <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GAP_W'(1);
               end
            end
            default: begin
               SS_n    <= 1'b1;
               MOSI    <= 1'b0;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed testbench for spi_master with a small behavioural SPI slave/RAM.
module tb_spi_master;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [9:0] din;
   logic       MISO;
   logic       busy;
   logic       done;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       SS_n;
   logic       MOSI;

   int n_tests = 0;
   int n_fail  = 0;

   logic rec_ss   [0:63];
   logic rec_mosi [0:63];
   logic rec_done [0:63];
   logic rec_rxv  [0:63];
   logic rec_busy [0:63];

   logic [7:0] s_ram [0:255];
   logic [7:0] s_addr;

   always #5 clk = ~clk;

   spi_master #(
      .FRAME_BITS (10),
      .DATA_BITS  (8),
      .GAP_CYCLES (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .din      (din),
      .busy     (busy),
      .done     (done),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // Start a frame and record outputs for n_cyc cycles; index c is cycle k+c
   task automatic run_frame(input logic [9:0] d, input logic [7:0] mb,
                            input int n_cyc, input bit hold, input bit disturb);
      @(negedge clk);
      din   = d;
      start = 1'b1;
      MISO  = 1'b0;
      @(posedge clk);
      for (int c = 0; c < n_cyc; c++) begin
         @(negedge clk);
         rec_ss[c]   = SS_n;
         rec_mosi[c] = MOSI;
         rec_done[c] = done;
         rec_rxv[c]  = rx_valid;
         rec_busy[c] = busy;
         if (!hold || c == n_cyc - 1) start = 1'b0;
         if (disturb && c == 3) begin
            din   = ~d;
            start = 1'b1;
         end
         MISO = (c >= 12 && c <= 19) ? mb[19 - c] : 1'b0;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; din = '0; MISO = 1'b0;
      #12;
      n_tests++;
      if ({SS_n, MOSI, busy, done, rx_valid} !== 5'b10000) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 10000", {SS_n, MOSI, busy, done, rx_valid});
      end
      n_tests++;
      if (rx_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data);
      end
      @(negedge clk); rst = 1'b0;
      begin
         int lows = 0;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (SS_n !== 1'b1 || busy !== 1'b0) lows++;
         end
         n_tests++;
         if (lows !== 0) begin
            n_fail++; $display("FAIL idle_after_reset: got %0d active cycles expected 0", lows);
         end
      end
   endtask

   task automatic test_write_frame;
      int lows = 0, dones = 0, rxvs = 0;
      logic [9:0] w;
      run_frame(10'b00_0000_0101, 8'h00, 30, 1'b0, 1'b0);
      for (int c = 0; c < 30; c++) begin
         if (rec_ss[c] === 1'b0) lows++;
         if (rec_done[c] === 1'b1) dones++;
         if (rec_rxv[c] === 1'b1) rxvs++;
      end
      for (int i = 0; i < 10; i++) w[9 - i] = rec_mosi[1 + i];
      n_tests++;
      if (lows !== 11) begin n_fail++; $display("FAIL wr_ss_low: got %0d expected 11", lows); end
      n_tests++;
      if ({rec_ss[0], rec_ss[10], rec_ss[11]} !== 3'b001) begin
         n_fail++; $display("FAIL wr_ss_edges: got %b expected 001", {rec_ss[0], rec_ss[10], rec_ss[11]});
      end
      n_tests++;
      if ({rec_mosi[0], w} !== {1'b0, 10'h005}) begin
         n_fail++; $display("FAIL wr_mosi: got %h expected 005", {rec_mosi[0], w});
      end
      n_tests++;
      if (dones !== 1 || rec_done[11] !== 1'b1) begin
         n_fail++; $display("FAIL wr_done: got count %0d at11 %b expected 1 1", dones, rec_done[11]);
      end
      n_tests++;
      if (rxvs !== 0) begin n_fail++; $display("FAIL wr_rx_valid: got %0d expected 0", rxvs); end
      n_tests++;
      if ({rec_mosi[11], rec_busy[11], rec_busy[12], rec_busy[0]} !== 4'b0101) begin
         n_fail++; $display("FAIL wr_gap: got %b expected 0101", {rec_mosi[11], rec_busy[11], rec_busy[12], rec_busy[0]});
      end
      n_tests++;
      if (rx_data !== 8'h00) begin n_fail++; $display("FAIL wr_rx_data: got %h expected 00", rx_data); end
   endtask

   task automatic test_start_ignored;
      int lows = 0, dones = 0;
      logic [9:0] w;
      run_frame(10'b01_1010_0110, 8'h00, 30, 1'b0, 1'b1);
      for (int c = 0; c < 30; c++) begin
         if (rec_ss[c] === 1'b0) lows++;
         if (rec_done[c] === 1'b1) dones++;
      end
      for (int i = 0; i < 10; i++) w[9 - i] = rec_mosi[1 + i];
      n_tests++;
      if (lows !== 11) begin n_fail++; $display("FAIL ign_ss_low: got %0d expected 11", lows); end
      n_tests++;
      if (w !== 10'h1A6) begin n_fail++; $display("FAIL ign_mosi: got %h expected 1a6", w); end
      n_tests++;
      if (dones !== 1) begin n_fail++; $display("FAIL ign_done: got %0d expected 1", dones); end
   endtask

   task automatic test_read_frame;
      int lows = 0, dones = 0, rxvs = 0;
      logic [9:0] w;
      run_frame(10'b11_0000_0000, 8'hA5, 30, 1'b0, 1'b0);
      for (int c = 0; c < 30; c++) begin
         if (rec_ss[c] === 1'b0) lows++;
         if (rec_done[c] === 1'b1) dones++;
         if (rec_rxv[c] === 1'b1) rxvs++;
      end
      for (int i = 0; i < 10; i++) w[9 - i] = rec_mosi[1 + i];
      n_tests++;
      if (lows !== 20) begin n_fail++; $display("FAIL rd_ss_low: got %0d expected 20", lows); end
      n_tests++;
      if ({rec_ss[19], rec_ss[20]} !== 2'b01) begin
         n_fail++; $display("FAIL rd_ss_edge: got %b expected 01", {rec_ss[19], rec_ss[20]});
      end
      n_tests++;
      if ({dones, rxvs} !== {32'd1, 32'd1} || {rec_done[20], rec_rxv[20]} !== 2'b11) begin
         n_fail++; $display("FAIL rd_pulses: got done %0d rxv %0d at20 %b expected 1 1 11", dones, rxvs, {rec_done[20], rec_rxv[20]});
      end
      n_tests++;
      if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL rd_rx_data: got %h expected a5", rx_data); end
      n_tests++;
      if ({w, rec_mosi[11]} !== {10'h300, 1'b0}) begin
         n_fail++; $display("FAIL rd_mosi: got %h turn %b expected 300 0", w, rec_mosi[11]);
      end
      n_tests++;
      if ({rec_busy[20], rec_busy[21]} !== 2'b10) begin
         n_fail++; $display("FAIL rd_busy: got %b expected 10", {rec_busy[20], rec_busy[21]});
      end
   endtask

   task automatic test_write_keeps_rx;
      int rxvs = 0;
      run_frame(10'b10_1100_0011, 8'hFF, 30, 1'b0, 1'b0);
      for (int c = 0; c < 30; c++) if (rec_rxv[c] === 1'b1) rxvs++;
      n_tests++;
      if (rx_data !== 8'hA5 || rxvs !== 0) begin
         n_fail++; $display("FAIL wr_keeps_rx: got %h rxv %0d expected a5 0", rx_data, rxvs);
      end
   endtask

   task automatic test_back_to_back;
      int dones = 0, lows = 0;
      run_frame(10'h15A, 8'h00, 39, 1'b1, 1'b0);
      for (int f = 0; f < 3; f++) begin
         int fl = 0;
         logic [9:0] w;
         for (int c = 13 * f; c < 13 * f + 13; c++) if (rec_ss[c] === 1'b0) fl++;
         for (int i = 0; i < 10; i++) w[9 - i] = rec_mosi[13 * f + 1 + i];
         n_tests++;
         if (fl !== 11 || {rec_ss[13 * f + 11], rec_ss[13 * f + 12]} !== 2'b11) begin
            n_fail++; $display("FAIL b2b_ss_frame%0d: got low %0d gap %b expected 11 11", f, fl, {rec_ss[13 * f + 11], rec_ss[13 * f + 12]});
         end
         n_tests++;
         if (w !== 10'h15A || rec_done[13 * f + 11] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_data_frame%0d: got %h done %b expected 15a 1", f, w, rec_done[13 * f + 11]);
         end
      end
      for (int c = 0; c < 39; c++) if (rec_done[c] === 1'b1) dones++;
      n_tests++;
      if (dones !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 3", dones); end
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (SS_n !== 1'b1) lows++;
      end
      n_tests++;
      if (lows !== 0) begin n_fail++; $display("FAIL b2b_no_queue: got %0d low cycles expected 0", lows); end
   endtask

   task automatic test_ram_sequence;
      logic [9:0] seq [0:3];
      seq[0] = {2'b00, 8'h1C}; seq[1] = {2'b01, 8'h3E};
      seq[2] = {2'b10, 8'h1C}; seq[3] = {2'b11, 8'h00};
      for (int a = 0; a < 256; a++) s_ram[a] = 8'h00;
      s_addr = 8'h00;
      for (int f = 0; f < 4; f++) begin
         logic [9:0] w;
         run_frame(seq[f], s_ram[s_addr], 30, 1'b0, 1'b0);
         for (int i = 0; i < 10; i++) w[9 - i] = rec_mosi[1 + i];
         n_tests++;
         if (w !== seq[f]) begin n_fail++; $display("FAIL ram_frame%0d: got %h expected %h", f, w, seq[f]); end
         case (w[9:8])
            2'b00:   s_addr = w[7:0];
            2'b01:   s_ram[s_addr] = w[7:0];
            2'b10:   s_addr = w[7:0];
            default: ;
         endcase
      end
      n_tests++;
      if (rx_data !== 8'h3E) begin n_fail++; $display("FAIL ram_readback: got %h expected 3e", rx_data); end
   endtask

   task automatic test_reset_midframe;
      int bad = 0, lows = 0, dones = 0;
      logic [9:0] w;
      @(negedge clk);
      din = 10'h3FF; start = 1'b1;
      @(posedge clk);
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if ({SS_n, MOSI, busy} !== 3'b100) begin
         n_fail++; $display("FAIL midrst_ctrl: got %b expected 100", {SS_n, MOSI, busy});
      end
      n_tests++;
      if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_data: got %h expected 00", rx_data); end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || rx_valid !== 1'b0 || SS_n !== 1'b1) bad++;
      end
      n_tests++;
      if (bad !== 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad); end
      run_frame(10'h2C3, 8'h00, 30, 1'b0, 1'b0);
      for (int c = 0; c < 30; c++) begin
         if (rec_ss[c] === 1'b0) lows++;
         if (rec_done[c] === 1'b1) dones++;
      end
      for (int i = 0; i < 10; i++) w[9 - i] = rec_mosi[1 + i];
      n_tests++;
      if (lows !== 11 || dones !== 1 || w !== 10'h2C3) begin
         n_fail++; $display("FAIL midrst_clean_frame: got low %0d done %0d data %h expected 11 1 2c3", lows, dones, w);
      end
   endtask

   initial begin
      test_reset();
      test_write_frame();
      test_start_ignored();
      test_read_frame();
      test_write_keeps_rx();
      test_back_to_back();
      test_ram_sequence();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset.
REQ-002 SHALL have parameter FRAME_BITS, default 10, command-plus-payload bits per frame.
REQ-003 SHALL have parameter DATA_BITS, default 8, read-back bits returned on MISO.
REQ-004 SHALL have parameter GAP_CYCLES, default 1, minimum SS_n-high cycles after a frame.
REQ-005 clk  input  1  system clock; all outputs registered on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  request one frame; sampled only in IDLE.
REQ-008 din  input  FRAME_BITS  frame word; din[9:8] command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), din[7:0] payload.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse at end of every frame.
REQ-011 rx_data  output  DATA_BITS  last byte read from MISO.
REQ-012 rx_valid  output  1  one-cycle pulse, rd-data frames only, coincident with done.
REQ-013 SS_n  output  1  active-low slave select.
REQ-014 MOSI  output  1  serial data to slave, MSB first.
REQ-015 MISO  input  1  serial data from slave, MSB first.

Function
REQ-016 States SHALL be IDLE, CMD, SHIFT, TURN, READ, GAP.
REQ-017 IDLE with start=1 at edge k SHALL capture din, drive SS_n=0 and MOSI=din[9], enter CMD (cycle k).
REQ-018 CMD SHALL last one cycle (slave command-select bit), then enter SHIFT.
REQ-019 SHIFT SHALL drive MOSI=din[9-i] in cycle k+1+i, i=0..9, with a 4-bit down-counter.
REQ-020 After SHIFT, commands 00/01/10 SHALL drive SS_n=1, MOSI=0 at edge k+11 and enter GAP; SS_n low exactly 11 cycles.
REQ-021 After SHIFT, command 11 SHALL enter TURN for one cycle (SS_n=0, MOSI=0), then READ.
REQ-022 READ SHALL sample MISO at the edge ending cycle k+12+j into rx_data bit 7-j, j=0..7; SS_n low exactly 20 cycles.
REQ-023 rx_data SHALL update only when READ completes (shadow shift register, commit on exit); unchanged by write-class frames.
REQ-024 done SHALL be high during the first GAP cycle; rx_valid likewise for rd-data frames.
REQ-025 GAP SHALL hold SS_n=1 for GAP_CYCLES cycles, then return to IDLE.
REQ-026 start while busy SHALL be ignored, no queueing; din changes after capture SHALL not affect the frame.
REQ-027 Back-to-back start SHALL give SS_n high for at least GAP_CYCLES+1 cycles between frames.
REQ-028 Unused/illegal state encodings SHALL recover to IDLE with SS_n=1.

Reset
REQ-029 rst=1 SHALL immediately force SS_n=1, MOSI=0, busy=0, done=0, rx_valid=0, rx_data=0, state IDLE, counters 0.
REQ-030 rst asserted mid-frame SHALL abort the frame with no done/rx_valid pulse; deassertion SHALL not start a frame unless start is high in IDLE afterwards.

Structure
REQ-031 Package spi_pkg SHALL hold state encoding, command codes (CMD_WR_ADDR..CMD_RD_DATA), FRAME_BITS/DATA_BITS defaults; shared with the slave and RAM.
REQ-032 One sub-module spi_master_shifter (load, shift-out MSB-first, shift-in, bit counter) is natural; FSM stays in spi_master.

Verification
REQ-033 din=10'b00_0000_0101, start 1 cycle -> SS_n low 11 cycles, MOSI 0,0,0,0,0,0,0,1,0,1 after CMD bit 0, done 1 pulse, rx_valid stays 0.
REQ-034 din=10'b11_0000_0000, MISO model returns 8'hA5 -> SS_n low 20 cycles, rx_data=8'hA5, rx_valid and done pulse same cycle.
REQ-035 Full RAM sequence via spi_slave+RAM: wr-addr 8'h1C, wr-data 8'h3E, rd-addr 8'h1C, rd-data -> rx_data=8'h3E.
REQ-036 start held high continuously across 3 frames -> each frame 11 cycles SS_n low, SS_n high >=2 cycles between; start pulses mid-frame ignored.
REQ-037 rst pulsed at cycle k+5 of rd-data frame -> SS_n=1 same cycle, no done/rx_valid, rx_data=0, next start runs a clean frame.
